// File: rtl/id_stage_decode.sv
// Decode stage: splits RV64 ALU instructions into EX fields, reads operands, and
// registers the bundle behind a 1-deep output register plus 1-entry skid buffer.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds ex_illegal and illegal_count).
module id_stage_decode #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [11:0]     ex_immed,
  output logic [XLEN-1:0] ex_reg1,
  output logic [XLEN-1:0] ex_reg2,
  output logic [4:0]      ex_rd,
  output logic            ex_wen,
  output logic [PC_W-1:0] ex_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal,
  output logic [31:0]     illegal_count
`endif
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned CNT_W = 32;

  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_OP32     = 7'b0111011;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [11:0]      immed;
    logic [XLEN-1:0]  reg1;
    logic [XLEN-1:0]  reg2;
    logic [4:0]       rd;
    logic             wen;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             illegal;
`endif
    logic [PC_W-1:0]  pc;
  } bundle_t;

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  bundle_t          out_q, out_d;
  bundle_t          skid_q, skid_d;
  bundle_t          dec;
  logic             legal;
  logic             itype;
  logic             accept;
  logic [OPC_W-1:0] opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [4:0]       rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic [CNT_W-1:0] count_q, count_d;
`endif

  assign opc         = if_instr[6:0];
  assign f3          = if_instr[14:12];
  assign f7          = if_instr[31:25];
  assign rd          = if_instr[11:7];
  assign rf_rs1_addr = if_instr[19:15];
  assign rf_rs2_addr = if_instr[24:20];

  // Flush blocks intake; a full skid buffer blocks intake independent of ex_ready.
  assign if_ready = !skid_valid_q && !flush;
  assign accept   = if_valid && if_ready;

  // Legality check and field extraction for the supported ALU subset.
  always_comb begin
    legal = 1'b0;
    itype = 1'b0;
    dec   = '0;
    case (opc)
      OPC_OP: legal = (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7))
                   || (f7 == 7'h20 && f3 == 3'd0);
      OPC_OP_IMM: begin
        itype = 1'b1;
        legal = (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7);
      end
      OPC_OP_IMM32: begin
        itype = 1'b1;
        legal = (f3 == 3'd0);
      end
      OPC_OP32: legal = (f3 == 3'd0) && (f7 == 7'h00 || f7 == 7'h20);
      default: legal = 1'b0;
    endcase

    dec.pc = if_pc;
    if (legal) begin
      dec.opcode = opc;
      dec.funct3 = f3;
      dec.funct7 = itype ? 7'h00 : f7;
      dec.immed  = itype ? if_instr[31:20] : 12'h000;
      dec.reg1   = rf_rs1_data;
      dec.reg2   = itype ? '0 : rf_rs2_data;
      dec.rd     = rd;
      dec.wen    = (rd != 5'd0);
    end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      dec.opcode  = opc;
      dec.funct3  = f3;
      dec.funct7  = f7;
      dec.immed   = if_instr[31:20];
      dec.reg1    = rf_rs1_data;
      dec.reg2    = rf_rs2_data;
      dec.rd      = rd;
      dec.wen     = 1'b0;
      dec.illegal = 1'b1;
`else
      dec.opcode = OPC_OP_IMM;
`endif
    end
  end

  // Output register / skid buffer next state; flush overrides everything.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || ex_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Saturating count of accepted illegal instructions.
  always_comb begin
    count_d = count_q;
    if (accept && !legal && count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      count_q      <= '0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
      count_q      <= count_d;
`endif
    end
  end

  assign ex_valid  = out_valid_q;
  assign ex_opcode = out_q.opcode;
  assign ex_funct3 = out_q.funct3;
  assign ex_funct7 = out_q.funct7;
  assign ex_immed  = out_q.immed;
  assign ex_reg1   = out_q.reg1;
  assign ex_reg2   = out_q.reg2;
  assign ex_rd     = out_q.rd;
  assign ex_wen    = out_q.wen;
  assign ex_pc     = out_q.pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign ex_illegal    = out_q.illegal;
  assign illegal_count = count_q;
`endif

endmodule

// File: tb/tb_id_stage_decode.sv
// Directed bench for id_stage_decode: decode fields, skid stall ordering,
// illegal handling, flush and mid-stall reset. Register file modelled as x[n] = 10*n.
module tb_id_stage_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [63:0] rf_rs1_data;
  logic [63:0] rf_rs2_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [11:0] ex_immed;
  logic [63:0] ex_reg1;
  logic [63:0] ex_reg2;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic [63:0] ex_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        ex_illegal;
  logic [31:0] illegal_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rs1_data = 64'(rf_rs1_addr) * 64'd10;
  assign rf_rs2_data = 64'(rf_rs2_addr) * 64'd10;

  id_stage_decode #(.XLEN(64), .PC_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_immed(ex_immed), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_pc(ex_pc)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal), .illegal_count(illegal_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd1);
    chk("rst_opcode", 64'(ex_opcode), 64'd0);
    chk("rst_pc", ex_pc, 64'd0);
    reset = 1'b1;
    tick();

    // addi x5,x1,-1
    offer(32'hFFF08293, 64'h100);
    chk("addi_rs1_addr", 64'(rf_rs1_addr), 64'd1);
    chk("addi_if_ready", 64'(if_ready), 64'd1);
    tick();
    chk("addi_valid", 64'(ex_valid), 64'd1);
    chk("addi_opcode", 64'(ex_opcode), 64'h13);
    chk("addi_immed", 64'(ex_immed), 64'hFFF);
    chk("addi_funct7", 64'(ex_funct7), 64'd0);
    chk("addi_reg1", ex_reg1, 64'd10);
    chk("addi_reg2", ex_reg2, 64'd0);
    chk("addi_rd", 64'(ex_rd), 64'd5);
    chk("addi_wen", 64'(ex_wen), 64'd1);
    chk("addi_pc", ex_pc, 64'h100);

    // sub x3,x1,x2
    offer(32'h402081B3, 64'h104);
    tick();
    if_valid = 1'b0;
    chk("sub_opcode", 64'(ex_opcode), 64'h33);
    chk("sub_funct3", 64'(ex_funct3), 64'd0);
    chk("sub_funct7", 64'(ex_funct7), 64'h20);
    chk("sub_immed", 64'(ex_immed), 64'd0);
    chk("sub_reg1", ex_reg1, 64'd10);
    chk("sub_reg2", ex_reg2, 64'd20);
    chk("sub_rd", 64'(ex_rd), 64'd3);
    chk("sub_wen", 64'(ex_wen), 64'd1);
    tick();
    chk("sub_drained", 64'(ex_valid), 64'd0);

    // Stall: addi x6,x2,5 / xori x7,x3,0xff / and x8,x1,x2
    ex_ready = 1'b0;
    offer(32'h00510313, 64'h200);
    tick();
    offer(32'h0FF1C393, 64'h204);
    chk("stall_b_ready", 64'(if_ready), 64'd1);
    tick();
    chk("stall_skid_full", 64'(if_ready), 64'd0);
    chk("stall_a_pc", ex_pc, 64'h200);
    offer(32'h0020F433, 64'h208);
    tick();
    chk("stall_c_blocked", 64'(if_ready), 64'd0);
    chk("stall_a_held_pc", ex_pc, 64'h200);
    chk("stall_a_held_imm", 64'(ex_immed), 64'h005);
    chk("stall_a_reg1", ex_reg1, 64'd20);
    ex_ready = 1'b1;
    tick();
    chk("rel_b_valid", 64'(ex_valid), 64'd1);
    chk("rel_b_pc", ex_pc, 64'h204);
    chk("rel_b_funct3", 64'(ex_funct3), 64'd4);
    chk("rel_b_immed", 64'(ex_immed), 64'h0FF);
    chk("rel_b_reg1", ex_reg1, 64'd30);
    chk("rel_ready", 64'(if_ready), 64'd1);
    tick();
    if_valid = 1'b0;
    chk("rel_c_pc", ex_pc, 64'h208);
    chk("rel_c_funct3", 64'(ex_funct3), 64'd7);
    chk("rel_c_reg2", ex_reg2, 64'd20);
    chk("rel_c_rd", 64'(ex_rd), 64'd8);
    tick();
    chk("rel_drained", 64'(ex_valid), 64'd0);

    // add x0,x1,x2 : no writeback
    offer(32'h00208033, 64'h300);
    tick();
    chk("x0_wen", 64'(ex_wen), 64'd0);
    chk("x0_opcode", 64'(ex_opcode), 64'h33);

    // opcode 0x7F: illegal
    offer(32'h12345FFF, 64'h304);
    tick();
    chk("ill_pc", ex_pc, 64'h304);
    chk("ill_wen", 64'(ex_wen), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", 64'(ex_illegal), 64'd1);
    chk("ill_opcode_raw", 64'(ex_opcode), 64'h7F);
    chk("ill_rd_raw", 64'(ex_rd), 64'd31);
    chk("ill_count1", 64'(illegal_count), 64'd1);
`else
    chk("ill_nop_opcode", 64'(ex_opcode), 64'h13);
    chk("ill_nop_funct3", 64'(ex_funct3), 64'd0);
    chk("ill_nop_immed", 64'(ex_immed), 64'd0);
    chk("ill_nop_rd", 64'(ex_rd), 64'd0);
`endif

    // funct7=0x01 on OP is not in the legal set
    offer(32'h022084B3, 64'h308);
    tick();
    chk("mul_wen", 64'(ex_wen), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("mul_count2", 64'(illegal_count), 64'd2);
`else
    chk("mul_nop_opcode", 64'(ex_opcode), 64'h13);
    chk("mul_nop_rd", 64'(ex_rd), 64'd0);
`endif

    // subw x10,x1,x2
    offer(32'h4020853B, 64'h30C);
    tick();
    if_valid = 1'b0;
    chk("subw_opcode", 64'(ex_opcode), 64'h3B);
    chk("subw_funct7", 64'(ex_funct7), 64'h20);
    chk("subw_rd", 64'(ex_rd), 64'd10);
    chk("subw_wen", 64'(ex_wen), 64'd1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("subw_legal", 64'(ex_illegal), 64'd0);
`endif
    tick();

    // Flush with output and skid both full
    ex_ready = 1'b0;
    offer(32'h00510313, 64'h400);
    tick();
    offer(32'h0FF1C393, 64'h404);
    tick();
    chk("fl_skid_full", 64'(if_ready), 64'd0);
    flush = 1'b1;
    offer(32'h0020F433, 64'h408);
    chk("fl_ready_forced", 64'(if_ready), 64'd0);
    tick();
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    #1;
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_ready", 64'(if_ready), 64'd1);
    tick();
    chk("fl_nothing", 64'(ex_valid), 64'd0);

    // Reset during a full stall
    ex_ready = 1'b0;
    offer(32'h00510313, 64'h500);
    tick();
    offer(32'h0FF1C393, 64'h504);
    tick();
    chk("rs_skid_full", 64'(if_ready), 64'd0);
    reset = 1'b0; if_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rs_valid", 64'(ex_valid), 64'd0);
    chk("rs_ready", 64'(if_ready), 64'd1);
    chk("rs_pc", ex_pc, 64'd0);
    chk("rs_reg1", ex_reg1, 64'd0);
    chk("rs_immed", 64'(ex_immed), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("rs_count", 64'(illegal_count), 64'd0);
`endif
    ex_ready = 1'b1;
    tick();
    chk("rs_nothing", 64'(ex_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
